uart_param: RTL

Parametrised full-duplex UART transmitter/receiver that replaces the fixed 8N1 link.
- Configurable data width, parity mode, stop-bit count and baud rate.
- Ready/valid transmit handshake.
- Receive-side false-start rejection, plus framing and parity error reporting.
- Sits between the board pins (`rx`/`tx`) and the byte-level consumers (FND display, echo loop, command decoders).

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_param.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ==== uart_pkg : shared constants and state encodings for uart_param ====
// Rev 1.0
`default_nettype none

package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ==== uart_baud_gen : free-running 16x oversampling tick, one clock wide ====
// Rev 1.0
`default_nettype none

module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_check
        $error("uart_baud_gen: CLK_HZ too low for 16x oversampling at BAUD");
    end

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CW'(DIV - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/uart_param.sv
// ==== uart_param : parametrised full-duplex UART (data width, parity, stop bits, baud) ====
// Rev 1.0
`default_nettype none

module uart_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] c_LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] c_LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          c_ODD       = (PARITY == PAR_ODD);
    localparam logic          c_PAR_EN    = (PARITY != PAR_NONE);

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_param_check
        $error("uart_param: illegal DATA_BITS/PARITY/STOP_BITS");
    end

    logic w_tick;

    uart_baud_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t            r_tx_state, w_tx_state_nxt;
    logic [3:0]           r_tx_tick,  w_tx_tick_nxt;
    logic [BW-1:0]        r_tx_bit,   w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                 r_tx_par,   w_tx_par_nxt;
    logic                 r_tx, r_tx_ready;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_tick_nxt  = r_tx_tick;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        if (r_tx_state != TX_IDLE && w_tick)
            w_tx_tick_nxt = r_tx_tick + 4'd1;
        case (r_tx_state)
            TX_IDLE: if (tx_valid && r_tx_ready) begin
                w_tx_state_nxt = TX_START;
                w_tx_tick_nxt  = 4'd0;
                w_tx_bit_nxt   = '0;
                w_tx_shift_nxt = tx_data;
                w_tx_par_nxt   = ^tx_data ^ c_ODD;
            end
            TX_START: if (w_tick && r_tx_tick == 4'd15)
                w_tx_state_nxt = TX_DATA;
            TX_DATA: if (w_tick && r_tx_tick == 4'd15) begin
                w_tx_shift_nxt = r_tx_shift >> 1;
                if (r_tx_bit == c_LAST_BIT) begin
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = c_PAR_EN ? TX_PARITY : TX_STOP;
                end else begin
                    w_tx_bit_nxt = r_tx_bit + 1'b1;
                end
            end
            TX_PARITY: if (w_tick && r_tx_tick == 4'd15)
                w_tx_state_nxt = TX_STOP;
            TX_STOP: if (w_tick && r_tx_tick == 4'd15) begin
                if (r_tx_bit == c_LAST_STOP) begin
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_IDLE;
                end else begin
                    w_tx_bit_nxt = r_tx_bit + 1'b1;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // Line and ready are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_tick  <= 4'd0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_tick  <= w_tx_tick_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_tx_ready <= (w_tx_state_nxt == TX_IDLE);
            case (w_tx_state_nxt)
                TX_START:  r_tx <= 1'b0;
                TX_DATA:   r_tx <= w_tx_shift_nxt[0];
                TX_PARITY: r_tx <= w_tx_par_nxt;
                default:   r_tx <= 1'b1;
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;

    // ---------------- receiver ----------------
    rx_state_t            r_rx_state, w_rx_state_nxt;
    logic [3:0]           r_rx_tick,  w_rx_tick_nxt;
    logic [BW-1:0]        r_rx_bit,   w_rx_bit_nxt;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                 r_rx_par,   w_rx_par_nxt;
    logic                 r_rx_s1, r_rx_s2;
    logic                 w_rx_done, w_rx_perr;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_rx_ferr, r_rx_perr;

    assign w_rx_perr = c_PAR_EN & (^r_rx_shift ^ r_rx_par ^ c_ODD);

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_tick_nxt  = r_rx_tick;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_par_nxt   = r_rx_par;
        w_rx_done      = 1'b0;
        if (r_rx_state != RX_IDLE && w_tick)
            w_rx_tick_nxt = r_rx_tick + 4'd1;
        case (r_rx_state)
            RX_IDLE: if (!r_rx_s2) begin
                w_rx_state_nxt = RX_START;
                w_rx_tick_nxt  = 4'd0;
                w_rx_bit_nxt   = '0;
            end
            RX_START: if (w_tick && r_rx_tick == 4'd7) begin
                w_rx_tick_nxt  = 4'd0;
                w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (w_tick && r_rx_tick == 4'd15) begin
                w_rx_shift_nxt = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                if (r_rx_bit == c_LAST_BIT) begin
                    w_rx_bit_nxt   = '0;
                    w_rx_state_nxt = c_PAR_EN ? RX_PARITY : RX_STOP;
                end else begin
                    w_rx_bit_nxt = r_rx_bit + 1'b1;
                end
            end
            RX_PARITY: if (w_tick && r_rx_tick == 4'd15) begin
                w_rx_par_nxt   = r_rx_s2;
                w_rx_state_nxt = RX_STOP;
            end
            RX_STOP: if (w_tick && r_rx_tick == 4'd15) begin
                w_rx_done      = 1'b1;
                w_rx_state_nxt = RX_IDLE;
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_tick  <= 4'd0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_perr  <= 1'b0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_state <= w_rx_state_nxt;
            r_rx_tick  <= w_rx_tick_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_par   <= w_rx_par_nxt;
            r_rx_valid <= w_rx_done;
            if (w_rx_done) begin
                r_rx_data <= r_rx_shift;
                r_rx_ferr <= ~r_rx_s2;
                r_rx_perr <= w_rx_perr;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_frame_err  = r_rx_ferr;
    assign rx_parity_err = r_rx_perr;

endmodule

`default_nettype wire
